ram_arbiter: RTL

//  Shares the single RAMControl port among NREQ requesters (Network, DNAInitializer, BubbleSort, spare).

---
 rtl/ram_arbiter_pkg.sv | 24 ++
 rtl/ram_arbiter_rr_pick.sv | 32 +++
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAMControl arbiter: bus widths, opcodes, FSM states, command record.
package ram_arbiter_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_BUSY  = 3'd2,
    ST_WAIT_READY = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  typedef struct packed {
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr (wrapping), one-hot out.
// Zero latency; any=0 when nothing is pending.
module ram_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  int slot;

  // Scan by distance from ptr; constant bit indices keep the mux free of variable part-selects.
  always_comb begin
    gnt  = '0;
    any  = 1'b0;
    slot = 0;
    for (int i = 0; i < NREQ; i++) begin
      slot = int'(ptr) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (!any && req[k] && (slot == k)) begin
          gnt[k] = 1'b1;
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAMControl port among NREQ requesters, one op in flight, optional lock.
// Req sampled in IDLE -> ramLatch next cycle -> done one cycle after ramReady returns; waits while ramReady=0.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ-1:0]        instr,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic                   ramInstruction,
  output logic                   ramLatch,
  output logic [ADDR_W-1:0]      ramBusAddr,
  output logic [DATA_W-1:0]      ramBusDataIn,
  input  logic [DATA_W-1:0]      ramBusDataOut,
  input  logic                   ramReady
);

  localparam int PW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;

  logic [NREQ-1:0]   pick_gnt;
  logic              pick_any;
  logic [NREQ-1:0]   sel;
  cmd_t              src_cmd;
  logic [PW-1:0]     owner_idx;
  logic [PW-1:0]     rr_next;
  logic              locked;
  logic              tmo_hit;

  ram_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Command source: the new winner when leaving IDLE, the current owner when a lock re-issues.
  assign sel = (state_q == ST_IDLE) ? pick_gnt : grant_q;

  always_comb begin
    src_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        src_cmd.instr = instr[i];
        src_cmd.addr  = addr[i*ADDR_W +: ADDR_W];
        src_cmd.wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner_idx = PW'(i);
    end
  end

  assign rr_next = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + PW'(1);
  assign locked  = |(grant_q & lock & req);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Never strobe a controller that has not finished its previous cycle.
        if (pick_any && ramReady) begin
          grant_d = pick_gnt;
          cmd_d   = src_cmd;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        tmo_d = tmo_q + 1'b1;
        if (!ramReady) begin
          state_d = ST_WAIT_READY;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_READY: begin
        tmo_d = tmo_q + 1'b1;
        if (ramReady) begin
          if (cmd_q.instr == OP_READ) rdata_d = ramBusDataOut;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (locked) begin
          cmd_d   = src_cmd;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          grant_d = '0;
          rr_d    = rr_next;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
      rr_q    <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign grant          = grant_q;
  assign done           = (state_q == ST_DONE) ? grant_q : '0;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign ramLatch       = (state_q == ST_ISSUE);
  assign ramInstruction = cmd_q.instr;
  assign ramBusAddr     = cmd_q.addr;
  assign ramBusDataIn   = cmd_q.wdata;

endmodule
